axi_wr_burst_sched: RTL and testbench

Burst scheduler that sequences the AXI burst write master: for each frame it issues one (address, length) command per burst into a rotating set of frame buffers, limits outstanding bursts, tracks write responses and reports frame completion/error. Sits between the frame-level control logic and the burst writer's command port; monitors the AXI B channel directly.

---
 rtl/axi_wr_burst_sched.sv | 164 ++++++++++++++++
 tb/tb_axi_wr_burst_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_burst_sched.sv
// axi_wr_burst_sched: sequences one (address, length) command per burst of a
// frame into a rotating set of frame buffers, throttles the number of bursts
// awaiting a write response, watches the AXI B channel and reports frame
// completion and write errors.
module axi_wr_burst_sched #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           BURST_LEN  = 16,
    parameter logic [ADDR_WIDTH-1:0] BUF_BASE   = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] BUF_SIZE   = 32'h0001_0000,
    parameter int unsigned           NUM_BUF    = 2,
    parameter int unsigned           MAX_OUT    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [15:0]           i_frame_bursts,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [7:0]            o_cmd_len,
    input  logic                  i_bvalid,
    input  logic [1:0]            i_bresp,
    output logic                  o_bready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [2:0]            o_buf_idx,
    output logic [2:0]            o_last_buf,
    output logic                  o_last_valid
);

    // Bytes moved by one burst; a power of two, so the in-buffer offset of
    // burst n is a shift followed by a wrap mask.
    localparam int unsigned           BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int unsigned           BB_SHIFT    = $clog2(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK    = BUF_SIZE - ADDR_WIDTH'(1);
    localparam logic [3:0]            MAX_OUT_C   = 4'(MAX_OUT);
    localparam logic [2:0]            LAST_IDX    = 3'(NUM_BUF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     frame_bursts_q;
    logic [15:0]     issued_q;
    logic [3:0]      outstanding_q;
    logic            cmd_hs;
    logic            b_dec;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    assign o_cmd_len = 8'(BURST_LEN - 1);
    assign cmd_hs    = o_cmd_valid & i_cmd_ready;

    // A B handshake only retires a burst when one is actually in flight;
    // responses left over from before a reset are absorbed here.
    assign b_dec = i_bvalid & o_bready & (outstanding_q != 4'd0);

    // Address of the next burst: buffer base plus the burst offset wrapped
    // inside the buffer, so oversized frames overwrite their own buffer.
    assign cmd_addr   = BUF_BASE + ADDR_WIDTH'(o_buf_idx) * BUF_SIZE
                      + ((ADDR_WIDTH'(issued_q) << BB_SHIFT) & OFF_MASK);
    assign o_cmd_addr = o_cmd_valid ? cmd_addr : '0;

    // Next-state and command/done decode.
    // NOTE: every output of a combinational block gets a default before the
    // case statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        o_cmd_valid = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = (i_frame_bursts == 16'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Valid depends only on registered state, so once raised it
                // stays up until the burst writer takes the command.
                o_cmd_valid = (outstanding_q < MAX_OUT_C);
                if (o_cmd_valid && i_cmd_ready &&
                    (issued_q == frame_bursts_q - 16'd1)) begin
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // No commands here, so the count reaches zero this cycle when
                // it equals the retirement (0 already, or 1 being retired).
                if (outstanding_q == 4'(b_dec)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame bookkeeping: counters, buffer rotation, status flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_bursts_q <= '0;
            issued_q       <= '0;
            outstanding_q  <= '0;
            o_bready       <= 1'b0;
            o_busy         <= 1'b0;
            o_err          <= 1'b0;
            o_buf_idx      <= '0;
            o_last_buf     <= '0;
            o_last_valid   <= 1'b0;
        end else begin
            o_bready      <= 1'b1;
            outstanding_q <= outstanding_q + 4'(cmd_hs) - 4'(b_dec);
            if (b_dec && (i_bresp != 2'b00)) begin
                o_err <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        frame_bursts_q <= i_frame_bursts;
                        issued_q       <= '0;
                        o_err          <= 1'b0;
                        o_busy         <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cmd_hs) begin
                        issued_q <= issued_q + 16'd1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    // An empty frame wrote nothing, so the buffer stays put.
                    if (frame_bursts_q != 16'd0) begin
                        o_last_buf   <= o_buf_idx;
                        o_last_valid <= 1'b1;
                        o_buf_idx    <= (o_buf_idx == LAST_IDX) ? 3'd0
                                                                : o_buf_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// tb_axi_wr_burst_sched: directed stimulus against a frame-level model of the
// burst scheduler, compared every cycle, plus hand-computed address and status
// expectations for the key scenarios.
module tb_axi_wr_burst_sched;

    localparam int unsigned BUF_BASE = 32'h1000_0000;
    localparam int unsigned BUF_SIZE = 32'h0001_0000;
    localparam int unsigned BB       = 128;
    localparam int          NUM_BUF  = 2;
    localparam int          MAX_OUT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame_bursts = '0;
    logic        cmd_ready = 1'b0;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    logic        cmd_valid;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        bready, busy, done, err, last_valid;
    logic [2:0]  buf_idx, last_buf;

    int n_vec = 0;
    int n_bad = 0;

    axi_wr_burst_sched dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_frame_bursts (frame_bursts),
        .o_cmd_valid    (cmd_valid),
        .i_cmd_ready    (cmd_ready),
        .o_cmd_addr     (cmd_addr),
        .o_cmd_len      (cmd_len),
        .i_bvalid       (bvalid),
        .i_bresp        (bresp),
        .o_bready       (bready),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_buf_idx      (buf_idx),
        .o_last_buf     (last_buf),
        .o_last_valid   (last_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit m_busy, m_done, m_err, m_last_valid, m_bready;
    int m_frames, m_sent, m_infl, m_buf, m_last_buf;

    function automatic bit m_valid();
        return m_busy && !m_done && (m_sent < m_frames) && (m_infl < MAX_OUT);
    endfunction

    function automatic logic [31:0] m_addr();
        return BUF_BASE + 32'(m_buf) * BUF_SIZE + 32'((m_sent * BB) % BUF_SIZE);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit c_hs, b_hs;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_last_valid = 0; m_bready = 0;
            m_frames = 0; m_sent = 0; m_infl = 0; m_buf = 0; m_last_buf = 0;
        end else begin
            c_hs = m_valid() && cmd_ready;
            b_hs = bvalid && m_bready;
            m_bready = 1;
            if (b_hs && m_infl > 0) begin
                if (bresp != 2'b00) m_err = 1;
                m_infl--;
            end
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
                if (m_frames != 0) begin
                    m_last_buf   = m_buf;
                    m_last_valid = 1;
                    m_buf        = (m_buf + 1) % NUM_BUF;
                end
            end else if (m_busy) begin
                if (c_hs) begin
                    m_sent++;
                    m_infl++;
                end
                if (m_sent == m_frames && m_infl == 0) m_done = 1;
            end else if (start) begin
                m_busy   = 1;
                m_frames = int'(frame_bursts);
                m_sent   = 0;
                m_err    = 0;
                m_done   = (frame_bursts == 16'd0);
            end
        end
    end

    // Per-cycle comparison, 1 time unit after the active edge.
    initial forever begin
        @(posedge clk);
        #1;
        check("cmd_valid", 32'(cmd_valid), 32'(m_valid()));
        if (m_valid() && cmd_valid) check("cmd_addr", cmd_addr, m_addr());
        if (!rst_n) check("rst_cmd_addr", cmd_addr, 32'h0);
        check("cmd_len", 32'(cmd_len), 32'd15);
        check("bready", 32'(bready), 32'(m_bready));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("buf_idx", 32'(buf_idx), 32'(m_buf));
        check("last_buf", 32'(last_buf), 32'(m_last_buf));
        check("last_valid", 32'(last_valid), 32'(m_last_valid));
    end

    // ---------------- handshake log and B responder ----------------
    logic [31:0] hs_addr[$];
    int due_q[$];
    int cyc = 0;
    bit b_auto = 0;
    int bad_idx = -1;
    int rel_req = 0;
    int rel_done = 0;
    int b_emitted = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            bvalid = 1'b0;
            bresp  = 2'b00;
        end else begin
            if (cmd_valid && cmd_ready) begin
                hs_addr.push_back(cmd_addr);
                if (b_auto) due_q.push_back(cyc + 2);
            end
            bvalid = 1'b0;
            bresp  = 2'b00;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                bvalid = 1'b1;
            end else if (rel_req > rel_done) begin
                rel_done++;
                bvalid = 1'b1;
            end
            if (bvalid) begin
                if (b_emitted == bad_idx) bresp = 2'b10;
                b_emitted++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input int n);
        frame_bursts = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int mark;
        tick();
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("bready_after_rst", 32'(bready), 32'd1);

        // Single frame of 3 bursts, B two cycles after each command.
        cmd_ready = 1'b1;
        b_auto = 1;
        mark = hs_addr.size();
        start_frame(3);
        check("t1_busy_n1", 32'(busy), 32'd1);
        check("t1_valid_n1", 32'(cmd_valid), 32'd1);
        wait_done(100);
        tick();
        check("t1_count", 32'(hs_addr.size() - mark), 32'd3);
        check("t1_addr0", hs_addr[mark], 32'h1000_0000);
        check("t1_addr1", hs_addr[mark + 1], 32'h1000_0080);
        check("t1_addr2", hs_addr[mark + 2], 32'h1000_0100);
        check("t1_buf_idx", 32'(buf_idx), 32'd1);
        check("t1_last_buf", 32'(last_buf), 32'd0);
        check("t1_last_valid", 32'(last_valid), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);

        // Three frames of 2 bursts: buffer rotation wraps at 2.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            mark = hs_addr.size();
            start_frame(2);
            wait_done(100);
            tick();
            check("t2_first_addr", hs_addr[mark], (f == 1) ? 32'h1001_0000 : 32'h1000_0000);
        end

        // Withheld B: outstanding limit, single release, simultaneous B + cmd.
        do_reset();
        b_auto = 0;
        mark = hs_addr.size();
        start_frame(8);
        repeat (8) tick();
        check("t3_hold_count", 32'(hs_addr.size() - mark), 32'd4);
        check("t3_hold_valid", 32'(cmd_valid), 32'd0);
        rel_req++;
        tick();
        check("t3_release_valid", 32'(cmd_valid), 32'd1);
        tick();
        tick();
        check("t3_release_count", 32'(hs_addr.size() - mark), 32'd5);
        check("t3_release_valid_low", 32'(cmd_valid), 32'd0);
        rel_req += 7;
        wait_done(60);
        tick();
        check("t3_total", 32'(hs_addr.size() - mark), 32'd8);

        // Ready stall, in-buffer wrap, bad response on burst 1.
        do_reset();
        b_auto = 1;
        cmd_ready = 1'b0;
        bad_idx = b_emitted + 1;
        mark = hs_addr.size();
        start_frame(513);
        repeat (5) begin
            tick();
            check("t4_stall_valid", 32'(cmd_valid), 32'd1);
            check("t4_stall_addr", cmd_addr, 32'h1000_0000);
        end
        cmd_ready = 1'b1;
        wait_done(2000);
        check("t4_err_at_done", 32'(err), 32'd1);
        tick();
        check("t4_err_sticky", 32'(err), 32'd1);
        check("t4_addr511", hs_addr[mark + 511], 32'h1000_FF80);
        check("t4_addr512", hs_addr[mark + 512], 32'h1000_0000);

        // Next frame clears o_err; a start while busy is ignored.
        mark = hs_addr.size();
        start_frame(2);
        check("t5_err_cleared", 32'(err), 32'd0);
        start_frame(7);
        wait_done(100);
        tick();
        check("t5_ignored_start", 32'(hs_addr.size() - mark), 32'd2);
        check("t5_idle", 32'(busy), 32'd0);

        // Zero-burst frame.
        mark = hs_addr.size();
        start_frame(0);
        check("t6_done_n1", 32'(done), 32'd1);
        tick();
        check("t6_done_gone", 32'(done), 32'd0);
        check("t6_buf_idx", 32'(buf_idx), 32'd0);
        check("t6_last_buf", 32'(last_buf), 32'd1);
        check("t6_no_cmds", 32'(hs_addr.size() - mark), 32'd0);

        // Reset mid-ISSUE, then a stray B must not underflow the count.
        b_auto = 0;
        start_frame(6);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(cmd_valid), 32'd0);
        check("t7_rst_addr", cmd_addr, 32'h0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_buf", 32'(buf_idx), 32'd0);
        check("t7_rst_last_valid", 32'(last_valid), 32'd0);
        check("t7_rst_bready", 32'(bready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rel_req++;
        tick();
        tick();
        mark = hs_addr.size();
        start_frame(5);
        repeat (8) tick();
        check("t7_post_stray_count", 32'(hs_addr.size() - mark), 32'd4);
        rel_req += 5;
        wait_done(60);
        tick();
        check("t7_total", 32'(hs_addr.size() - mark), 32'd5);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
